// File: rtl/mux_4_1_rr_arb.sv
// Round-robin arbitrated 4:1 mux: one requester at a time owns the registered output Y.
// Optional forced rotation after MAX_HOLD cycles is compiled in with MUX_RR_TIMEOUT_EN.
module mux_4_1_rr_arb #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] REQ,
  input  logic [3:0] I,
  output logic [3:0] GNT,
  output logic [1:0] S,
  output logic       Y,
  output logic       Y_VALID
);

`ifdef MUX_RR_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;
  logic [1:0] rst_sync;
  logic       rst_int_n;

  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       timeout_hit;
  logic       do_grant;
  logic       go_idle;
  logic [1:0] win;

  // First set bit of req scanning upward from start (mod 4); MSB flags a hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // GNT is one-hot at S while granted, so masking it leaves the competing requests.
  assign others      = REQ & ~GNT;
  assign pick_idle   = rr_pick(REQ, ptr);
  assign pick_next   = rr_pick(others, S + 2'd1);
  assign timeout_hit = TIMEOUT_EN && (hold_cnt == 4'(MAX_HOLD)) && (|others);

  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
    win      = pick_idle[1:0];
    if (state == IDLE) begin
      do_grant = pick_idle[2];
    end else if (!REQ[S] || timeout_hit) begin
      if (pick_next[2]) begin
        do_grant = 1'b1;
        win      = pick_next[1:0];
      end else begin
        go_idle = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      GNT      <= 4'b0000;
      S        <= 2'b00;
      ptr      <= 2'b00;
      hold_cnt <= 4'd0;
      Y        <= 1'b0;
      Y_VALID  <= 1'b0;
    end else begin
      Y       <= (state == GRANT) ? I[S] : 1'b0;
      Y_VALID <= (state == GRANT);
      if (do_grant) begin
        state    <= GRANT;
        GNT      <= 4'b0001 << win;
        S        <= win;
        ptr      <= win + 2'd1;
        hold_cnt <= 4'd1;
      end else if (go_idle) begin
        state    <= IDLE;
        GNT      <= 4'b0000;
        hold_cnt <= 4'd0;
      end else if (state == GRANT && hold_cnt != 4'd15) begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr_arb.sv
// Self-checking bench for mux_4_1_rr_arb: directed scenarios plus random traffic
// compared against an integer-based reference model of the arbitration rules.
module tb_mux_4_1_rr_arb;

`ifdef MUX_RR_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       y;
  logic       y_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner -1 means nobody holds the output.
  int   m_owner, m_ptr, m_hold, m_s;
  logic m_y, m_yv;

  mux_4_1_rr_arb #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n), .REQ(req), .I(din),
    .GNT(gnt), .S(s), .Y(y), .Y_VALID(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int off = 0; off < 4; off++)
      if (r[(start + off) % 4]) return (start + off) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_take(input int w);
    m_owner = w;
    m_s     = w;
    m_ptr   = (w + 1) % 4;
    m_hold  = 1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_s = 0; m_y = 1'b0; m_yv = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    logic [3:0] oth;
    bit keep;
    if (m_owner < 0) begin
      m_y = 1'b0; m_yv = 1'b0;
      if (r != 4'b0000) model_take(first_from(r, m_ptr));
    end else begin
      m_y  = d[m_owner];
      m_yv = 1'b1;
      oth  = r & ~4'(1 << m_owner);
      keep = r[m_owner] && !(TO && m_hold == MAXH && oth != 4'b0000);
      if (keep) m_hold = (m_hold < 15) ? m_hold + 1 : 15;
      else if (oth != 4'b0000) model_take(first_from(oth, m_owner + 1));
      else begin m_owner = -1; m_hold = 0; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt()));
    chk({tag, ".s"},   32'(s),   32'(m_s));
    chk({tag, ".y"},   32'(y),   32'(m_y));
    chk({tag, ".yv"},  32'(y_valid), 32'(m_yv));
  endtask

  task automatic step(input string tag);
    logic [3:0] r, d;
    r = req; d = din;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_gnt"}, 32'(gnt), 32'h0);
    chk({tag, ".rst_s"},   32'(s),   32'h0);
    chk({tag, ".rst_y"},   32'(y),   32'h0);
    chk({tag, ".rst_yv"},  32'(y_valid), 32'h0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step({tag, ".rel"});
  endtask

  logic [3:0] fair_req [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1101,
                               4'b1101, 4'b1011, 4'b1011, 4'b0111};
  logic [3:0] fair_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                               4'b0100, 4'b1000, 4'b1000, 4'b0001};

  initial begin
    model_reset();
    do_reset("init");

    // Reset mid-grant, then first grant after release starts from PTR = 0.
    req = 4'b0100; step("pre_rst");
    step("pre_rst2");
    do_reset("mid");
    req = 4'b1000; step("rst_after");
    chk("rst_after.gnt3", 32'(gnt), 32'h8);
    chk("rst_after.s3",   32'(s),   32'd3);

    // Fairness: all request, each owner drops after two cycles.
    do_reset("fair");
    for (int k = 0; k < 9; k++) begin
      req = fair_req[k];
      step("fair");
      chk("fair.order", 32'(gnt), 32'(fair_gnt[k]));
    end

    // Data path through requester 2.
    req = 4'b0000; step("dp_idle");
    req = 4'b0100; din = 4'b0100; step("dp_g");
    chk("dp.gnt", 32'(gnt), 32'h4);
    step("dp_y1");
    chk("dp.y1", 32'({y, y_valid}), 32'b11);
    din = 4'b1011; step("dp_y0");
    chk("dp.y0", 32'({y, y_valid}), 32'b01);

    // Release to idle from a sole requester; PTR must land on 2.
    req = 4'b0000; step("rel_a");
    req = 4'b0010; step("rel_g");
    req = 4'b0000; step("rel_drop");
    chk("rel.gnt0", 32'(gnt), 32'h0);
    chk("rel.yv_late", 32'(y_valid), 32'h1);
    step("rel_idle");
    chk("rel.yv0", 32'(y_valid), 32'h0);
    req = 4'b1111; step("rel_ptr");
    chk("rel.ptr2", 32'(gnt), 32'h4);

    // Wrap: PTR = 3 with requesters 3 and 0.
    req = 4'b0000; step("wrap_idle");
    req = 4'b1001; step("wrap3");
    chk("wrap.g3", 32'(gnt), 32'h8);
    req = 4'b0001; step("wrap0");
    chk("wrap.g0", 32'(gnt), 32'h1);

    // Two requesters holding forever: rotation only with the timeout built in.
    do_reset("to");
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      step("to");
      chk("to.gnt", 32'(gnt), TO ? (((c / MAXH) % 2) ? 32'h2 : 32'h1) : 32'h1);
    end

    // Random traffic, with one asynchronous reset in the middle.
    req = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
      din = 4'($urandom_range(0, 15));
      if (c == 200) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "simulation time limit");
  end

endmodule
